// File: rtl/load_return_pkg.sv
// Shared load-path definitions: funct3 load encodings, default queue depth
// and the load-queue entry layout used by load_return and load_align.
package load_return_pkg;

  localparam int QUEUE_DEPTH_DEFAULT = 2;

  // RISC-V load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One outstanding load: issue-time info plus the aligned result once done
  typedef struct packed {
    logic [4:0]  rd;
    logic [1:0]  addr_low;
    logic [2:0]  funct3;
    logic [31:0] data;
    logic        done;
  } entry_t;

endpackage

// File: rtl/load_return_align.sv
// load_align: selects the addressed byte/half of a returned bus word and
// sign- or zero-extends it according to the load funct3. Unknown codes
// behave as LW.
module load_align
  import load_return_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_low,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branching, so no path can leave it holding its old value (a latch).
    value    = word;
    byte_sel = word[{addr_low, 3'b000} +: 8];
    half_sel = addr_low[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   value = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  value = {24'h0, byte_sel};
      F3_LHU:  value = {16'h0, half_sel};
      F3_LW:   value = word;
      default: value = word;
    endcase
  end

endmodule

// File: rtl/load_return.sv
// load_return: in-order load return queue between the execute stage, the
// data bus and writeback. Loads are allocated at tail, filled in issue
// order at fill, and retired in order at head.
// Optional feature: define LOAD_TIMEOUT_EN to force-complete a load whose
// bus return has not arrived within TIMEOUT_CYCLES cycles.
module load_return
  import load_return_pkg::*;
#(
  parameter int QUEUE_DEPTH    = QUEUE_DEPTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rd,
  input  logic [1:0]  issue_addr_low,
  input  logic [2:0]  issue_funct3,
  input  logic        bus_read_data_valid,
  input  logic [31:0] bus_read_data,
  output logic        result_valid,
  output logic [4:0]  result_rd,
  output logic [31:0] result_data,
  input  logic        result_ack,
  output logic        pending,
  output logic        timeout_error
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  // Pointers carry one extra wrap bit so that "full" and "empty" (and
  // "all filled" vs "none filled") are distinguishable; the low AW bits
  // are the slot index and wrap modulo QUEUE_DEPTH.
  localparam int PW = AW + 1;

  if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  entry_t          entries [QUEUE_DEPTH];
  logic [PW-1:0]   tail, fill, head, occupancy;
  logic [AW-1:0]   tail_idx, fill_idx, head_idx;
  logic            do_issue, do_return, do_retire, do_timeout, fill_done;
  logic            has_unfilled;
  logic [31:0]     aligned, fill_data;

  assign tail_idx  = tail[AW-1:0];
  assign fill_idx  = fill[AW-1:0];
  assign head_idx  = head[AW-1:0];
  assign occupancy = tail - head;

  assign issue_ready  = (occupancy != PW'(QUEUE_DEPTH));
  assign pending      = (tail != head);
  assign has_unfilled = (fill != tail);

  assign result_valid = entries[head_idx].done;
  assign result_rd    = entries[head_idx].rd;
  assign result_data  = entries[head_idx].data;

  assign do_issue  = issue_valid && issue_ready;
  assign do_return = bus_read_data_valid && has_unfilled;
  assign do_retire = result_ack && result_valid;
  assign fill_done = do_return || do_timeout;
  assign fill_data = do_return ? aligned : 32'h0;

  load_align u_align (
    .word     (bus_read_data),
    .addr_low (entries[fill_idx].addr_low),
    .funct3   (entries[fill_idx].funct3),
    .value    (aligned)
  );

  // Allocate at tail, fill at fill, retire at head; all three may coincide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tail <= '0;
      fill <= '0;
      head <= '0;
      // NOTE: the queue is only a few entries, so the whole array is reset;
      // that keeps result_rd/result_data at zero out of reset rather than
      // showing whatever a discarded load left behind.
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (do_retire) begin
        entries[head_idx].done <= 1'b0;
        head                   <= head + 1'b1;
      end
      if (fill_done) begin
        entries[fill_idx].data <= fill_data;
        entries[fill_idx].done <= 1'b1;
        fill                   <= fill + 1'b1;
      end
      if (do_issue) begin
        entries[tail_idx] <= '{rd: issue_rd, addr_low: issue_addr_low,
                               funct3: issue_funct3, data: 32'h0, done: 1'b0};
        tail              <= tail + 1'b1;
      end
    end
  end

`ifdef LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_flag;

  // Fire on the cycle the count would reach TIMEOUT_CYCLES with no return
  assign do_timeout    = has_unfilled && !bus_read_data_valid &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_error = timeout_flag;

  // Count idle cycles of the oldest unfilled load; sticky error on expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else if (do_return || !has_unfilled) begin
      wait_cnt <= '0;
    end else if (do_timeout) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign do_timeout    = 1'b0;
  assign timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_load_return.sv
// Self-checking bench for load_return: directed scenarios for the key
// behaviours followed by randomized traffic, all compared against a
// transaction-level queue model. Define LOAD_TIMEOUT_EN to also exercise
// forced completion (bench uses TIMEOUT_CYCLES = 4).
module tb_load_return;
  import load_return_pkg::*;

  localparam int DEPTH = 2;
  localparam int TMO   = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_rd = '0;
  logic [1:0]  issue_addr_low = '0;
  logic [2:0]  issue_funct3 = '0;
  logic        bus_read_data_valid = 1'b0;
  logic [31:0] bus_read_data = '0;
  logic        result_valid;
  logic [4:0]  result_rd;
  logic [31:0] result_data;
  logic        result_ack = 1'b0;
  logic        pending;
  logic        timeout_error;

  int tests = 0;
  int failures = 0;

  load_return #(.QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_rd            (issue_rd),
    .issue_addr_low      (issue_addr_low),
    .issue_funct3        (issue_funct3),
    .bus_read_data_valid (bus_read_data_valid),
    .bus_read_data       (bus_read_data),
    .result_valid        (result_valid),
    .result_rd           (result_rd),
    .result_data         (result_data),
    .result_ack          (result_ack),
    .pending             (pending),
    .timeout_error       (timeout_error)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  a;
    logic [2:0]  f3;
    logic [31:0] data;
    bit          done;
  } mload_t;

  mload_t q[$];
  int     wcnt = 0;
  bit     terr = 1'b0;

  function automatic logic [31:0] align_model(logic [31:0] w, logic [1:0] a, logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    bit exp_valid;
    exp_valid = (q.size() > 0) && q[0].done;
    check("issue_ready", issue_ready, (q.size() < DEPTH));
    check("pending", pending, (q.size() != 0));
    check("result_valid", result_valid, exp_valid);
    check("timeout_error", timeout_error, terr);
    if (exp_valid) begin
      check("result_rd", result_rd, q[0].rd);
      check("result_data", result_data, q[0].data);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic step(input bit iv, input logic [4:0] rd, input logic [1:0] a,
                      input logic [2:0] f3, input bit bv, input logic [31:0] bd,
                      input bit ack);
    int  fidx;
    bit  accept, retire;
    issue_valid         = iv;
    issue_rd            = rd;
    issue_addr_low      = a;
    issue_funct3        = f3;
    bus_read_data_valid = bv;
    bus_read_data       = bd;
    result_ack          = ack;

    accept = iv && (q.size() < DEPTH);
    retire = ack && (q.size() > 0) && q[0].done;
    fidx = -1;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!q[i].done) fidx = i;
    end
    if (fidx >= 0 && bv) begin
      q[fidx].data = align_model(bd, q[fidx].a, q[fidx].f3);
      q[fidx].done = 1'b1;
    end
`ifdef LOAD_TIMEOUT_EN
    if (fidx >= 0 && !bv) begin
      wcnt++;
      if (wcnt == TMO) begin
        q[fidx].data = 32'h0;
        q[fidx].done = 1'b1;
        terr = 1'b1;
        wcnt = 0;
      end
    end else begin
      wcnt = 0;
    end
`endif
    if (retire) void'(q.pop_front());
    if (accept) q.push_back('{rd: rd, a: a, f3: f3, data: 32'h0, done: 1'b0});

    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic model_reset();
    q.delete();
    wcnt = 0;
    terr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #1;
    check("rst_issue_ready", issue_ready, 1'b1);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_pending", pending, 1'b0);
    check("rst_result_rd", result_rd, 5'd0);
    check("rst_result_data", result_data, 32'h0);
    check("rst_timeout_error", timeout_error, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle();

    // LB rd=5 addr_low=3, return 0x80FF_FF00
    step(1'b1, 5'd5, 2'd3, F3_LB, 1'b0, 32'h0, 1'b0);
    check("lb_not_yet_valid", result_valid, 1'b0);
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b1, 32'h80FF_FF00, 1'b0);
    check("lb_valid", result_valid, 1'b1);
    check("lb_rd", result_rd, 5'd5);
    check("lb_data", result_data, 32'hFFFF_FF80);
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b0, 32'h0, 1'b1);
    check("lb_retired_pending", pending, 1'b0);

    // LHU addr_low=2 then LW; results in issue order
    step(1'b1, 5'd7, 2'd2, F3_LHU, 1'b0, 32'h0, 1'b0);
    step(1'b1, 5'd8, 2'd0, F3_LW, 1'b1, 32'hBEEF_1234, 1'b0);
    check("lhu_data", result_data, 32'h0000_BEEF);
    check("lhu_rd", result_rd, 5'd7);
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b1, 32'h0000_0007, 1'b0);
    check("lhu_still_head", result_data, 32'h0000_BEEF);
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b0, 32'h0, 1'b1);
    check("lw_data", result_data, 32'h0000_0007);
    check("lw_rd", result_rd, 5'd8);
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b0, 32'h0, 1'b1);

    // Full queue refuses a third issue; ack + return frees a slot
    step(1'b1, 5'd1, 2'd0, F3_LW, 1'b0, 32'h0, 1'b0);
    step(1'b1, 5'd2, 2'd1, F3_LB, 1'b0, 32'h0, 1'b0);
    check("full_ready", issue_ready, 1'b0);
    step(1'b1, 5'd3, 2'd0, F3_LW, 1'b0, 32'h0, 1'b0);
    check("full_refused", issue_ready, 1'b0);
    step(1'b1, 5'd3, 2'd0, F3_LW, 1'b1, 32'h1111_2222, 1'b0);
    check("full_head_rd", result_rd, 5'd1);
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b1, 32'h0000_9A00, 1'b1);
    check("slot_freed", issue_ready, 1'b1);
    check("second_rd", result_rd, 5'd2);
    check("second_data", result_data, 32'hFFFF_FF9A);
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b0, 32'h0, 1'b1);

    // Stray return with an empty queue is ignored
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("stray_valid", result_valid, 1'b0);
    check("stray_pending", pending, 1'b0);

    // Reset with a load in flight discards it immediately
    step(1'b1, 5'd9, 2'd0, F3_LW, 1'b0, 32'h0, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("midrst_pending", pending, 1'b0);
    check("midrst_ready", issue_ready, 1'b1);
    check("midrst_valid", result_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b1, 32'h5555_5555, 1'b0);
    check("stale_return_valid", result_valid, 1'b0);

`ifdef LOAD_TIMEOUT_EN
    // Unanswered load is force-completed after TIMEOUT_CYCLES
    step(1'b1, 5'd4, 2'd0, F3_LW, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) idle();
    check("tmo_not_yet", result_valid, 1'b0);
    idle();
    check("tmo_valid", result_valid, 1'b1);
    check("tmo_data", result_data, 32'h0);
    check("tmo_error", timeout_error, 1'b1);
    step(1'b0, 5'd0, 2'd0, 3'd0, 1'b0, 32'h0, 1'b1);
    idle();
    check("tmo_sticky", timeout_error, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("tmo_cleared", timeout_error, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(1, 0) == 1,
           5'($urandom),
           2'($urandom),
           3'($urandom),
           $urandom_range(9, 0) < 4,
           $urandom,
           $urandom_range(1, 0) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/load_return.md
LOAD_RETURN -- requirements
Module: load_return

Interface
REQ-001 Param QUEUE_DEPTH, default 2, max loads in flight plus completed-but-unretired (power of 2, >=2).
REQ-002 Param TIMEOUT_CYCLES, default 255, cycles an unfilled load may wait before forced completion (only with LOAD_TIMEOUT_EN).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 issue_valid  in  1  execute stage issues a load to the bus this cycle.
REQ-006 issue_ready  out  1  a queue slot is free; a load is accepted when issue_valid && issue_ready.
REQ-007 issue_rd  in  5  destination register of issued load.
REQ-008 issue_addr_low  in  2  byte offset of load address.
REQ-009 issue_funct3  in  3  load width/sign code.
REQ-010 bus_read_data_valid  in  1  bus returns one read word this cycle; no backpressure.
REQ-011 bus_read_data  in  32  returned word.
REQ-012 result_valid  out  1  oldest load is complete and presented to writeback.
REQ-013 result_rd  out  5  rd of presented load.
REQ-014 result_data  out  32  aligned, extended load value.
REQ-015 result_ack  in  1  writeback consumes presented result (writeback enable && ready).
REQ-016 pending  out  1  at least one issued load not yet retired; drives writeback ready gating.
REQ-017 timeout_error  out  1  sticky flag, a load was force-completed.

Function
REQ-018 Queue SHALL be a circular buffer of QUEUE_DEPTH entries {rd, addr_low, funct3, data, done} with tail (allocate), fill and head (retire) pointers, each wrapping modulo QUEUE_DEPTH.
REQ-019 Accepted issue SHALL write the entry at tail with done=0 and advance tail; issue_ready = occupancy < QUEUE_DEPTH.
REQ-020 Bus returns SHALL be in issue order; a return SHALL write aligned data into the entry at fill, set done, advance fill.
REQ-021 bus_read_data_valid with no unfilled entry (fill == tail) SHALL be ignored without state change.
REQ-022 result_valid SHALL equal head entry done; data visible the cycle after capture (1-cycle latency, no bypass).
REQ-023 result_ack with result_valid SHALL free head and advance it; result_ack without result_valid SHALL be ignored.
REQ-024 Issue, return and retire in one cycle SHALL all take effect; issue when full is refused even if retire occurs that cycle.
REQ-025 Alignment: funct3 000 LB byte[addr_low] sign-ext; 001 LH half[addr_low[1]] sign-ext, addr_low[0] ignored; 010 LW whole word; 100 LBU, 101 LHU zero-ext; any other code treated as LW.
REQ-026 pending = occupancy != 0.

Reset
REQ-027 reset_n low SHALL immediately clear all pointers, occupancy, done bits, timeout counter and timeout_error; outputs reset to issue_ready=1, result_valid=0, pending=0, result_rd=0, result_data=0.
REQ-028 Reset mid-operation SHALL discard in-flight loads; subsequent stale bus returns fall under REQ-021.

Configuration
REQ-029 Macro LOAD_TIMEOUT_EN defined: a counter SHALL increment each cycle an unfilled entry exists without a return, clear on any return or when none unfilled; on reaching TIMEOUT_CYCLES the fill entry SHALL complete with data 0, fill advance, timeout_error set sticky.
REQ-030 LOAD_TIMEOUT_EN undefined: no counter; timeout_error tied 0; loads wait indefinitely.

Structure
REQ-031 Shared CPU package SHALL hold load funct3 encodings, QUEUE_DEPTH default and the queue entry typedef.
REQ-032 One combinational sub-module load_align (word, addr_low, funct3 -> 32-bit value) SHALL implement REQ-025.

Verification
REQ-033 Issue LB rd=5 addr_low=3, return 0x80FF_FF00 -> next cycle result_valid=1, rd=5, data=0xFFFF_FF80.
REQ-034 Issue LHU addr_low=2 then LW, returns 0xBEEF_1234 then 0x0000_0007 -> results 0x0000_BEEF then 0x0000_0007, in order.
REQ-035 Issue 2 loads no ack, third issue_valid -> issue_ready=0, third refused; ack + return same cycle -> slot frees next cycle.
REQ-036 Return with empty queue, then reset_n pulse with 1 load pending -> no result, pending=0, issue_ready=1 immediately.
REQ-037 LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4, issue with no return -> after 4 cycles result_valid=1, data=0, timeout_error=1 until reset.
